// File: rtl/serial_frame_rx_pkg.sv
// Shared definitions for the single-wire serial link (receiver and transmitter).
package serial_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    BREAK
  } link_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // 0 = even parity, 1 = odd parity
  localparam logic PARITY_MODE = 1'b0;

  function automatic logic parity_mismatch(input logic parity_bit, input logic running_xor);
    return parity_bit ^ running_xor ^ PARITY_MODE;
  endfunction

endpackage

// File: rtl/serial_frame_rx_if.sv
// Parallel-side handshake of the serial frame receiver.
interface serial_frame_rx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              parity_err;
  logic              frame_err;
  logic              overrun;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, frame_err, overrun,
    output rx_ready
  );
endinterface

// File: rtl/serial_frame_rx_sync_chain.sv
// Multi-flop synchroniser; resets to the idle line level so reset never looks like a start bit.
module sync_chain
  import serial_link_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ff <= {SYNC_STAGES{LINE_IDLE}};
    else        ff <= {ff[SYNC_STAGES-2:0], d};
  end

  assign q = ff[SYNC_STAGES-1];
endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start detect, LSB-first shift, optional parity, stop check, valid/ready out.
//   state  | meaning
//   IDLE   | line idle, waiting for start bit
//   DATA   | shifting in payload bits
//   PARITY | sampling the parity bit
//   STOP   | sampling stop bit, deliver or flag
//   BREAK  | bad stop seen, wait for line to return high
module serial_frame_rx
  import serial_link_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter bit PARITY_EN   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 serial_in,
  serial_frame_rx_if.master    rx
);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic              s;
  link_state_t       state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shift;
  logic              run_xor;
  logic              mismatch;
  logic              last_bit;
  logic              deliver;
  logic              drop;

  sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (serial_in),
    .q     (s)
  );

  assign last_bit = (cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    deliver   = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE:   if (s == START_BIT) state_nxt = DATA;
      DATA:   if (last_bit) state_nxt = PARITY_EN ? PARITY : STOP;
      PARITY: state_nxt = STOP;
      STOP: begin
        if (s == STOP_BIT) begin
          state_nxt = IDLE;
          deliver   = !rx.rx_valid || rx.rx_ready;
          drop      = rx.rx_valid && !rx.rx_ready;
        end else begin
          state_nxt = BREAK;
        end
      end
      BREAK:  if (s == LINE_IDLE) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt           <= '0;
      shift         <= '0;
      run_xor       <= 1'b0;
      mismatch      <= 1'b0;
      rx.rx_data    <= '0;
      rx.rx_valid   <= 1'b0;
      rx.parity_err <= 1'b0;
      rx.frame_err  <= 1'b0;
      rx.overrun    <= 1'b0;
    end else begin
      rx.frame_err <= (state == STOP) && (s != STOP_BIT);
      rx.overrun   <= drop;

      case (state)
        IDLE: begin
          cnt      <= '0;
          run_xor  <= 1'b0;
          mismatch <= 1'b0;
        end
        DATA: begin
          shift[cnt] <= s;
          run_xor    <= run_xor ^ s;
          cnt        <= cnt + 1'b1;
        end
        PARITY: mismatch <= parity_mismatch(s, run_xor);
        default: ;
      endcase

      // a same-edge accept and new delivery keeps rx_valid high
      if (deliver) begin
        rx.rx_data    <= shift;
        rx.parity_err <= mismatch;
        rx.rx_valid   <= 1'b1;
      end else if (rx.rx_valid && rx.rx_ready) begin
        rx.rx_valid   <= 1'b0;
      end
    end
  end
endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Synchronous serial frame receiver; the receive end of the single-wire registered serial output our pipelined netlists drive (one bit per clk, idle-high line).
- Synchronises `serial_in`, detects the start bit, shifts in DATA_W bits LSB-first, checks optional even parity and the stop bit.
- Presents the parallel word on a valid/ready handshake to downstream logic.
- Sits at the capture side of the link in the STA test designs, giving a register-to-register path target.

Parameters:
- DATA_W, 8, payload bits per frame (1..32).
- PARITY_EN, 1, 1 = one even-parity bit follows the data; 0 = no parity bit.
- SYNC_STAGES, 2, flops in the `serial_in` synchroniser (>=2).

Ports:
- clk  input  1  single clock; all flops rising-edge.
- reset  input  1  asynchronous, active-low reset (assert low, deassert sync'd externally).
- serial_in  input  1  serial line, idle 1, one bit per clk.
- rx_data  output  DATA_W  received word, valid while rx_valid=1.
- rx_valid  output  1  word available; held until accepted.
- rx_ready  input  1  downstream accepts when rx_valid&rx_ready at a rising edge.
- parity_err  output  1  parity mismatch on the held word; qualified by rx_valid.
- frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- overrun  output  1  one-cycle pulse: completed frame dropped because the previous word was not accepted.

Behaviour:
- Reset (reset=0, async):
  - Synchroniser flops -> 1.
  - FSM -> IDLE.
  - rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0; bit counter=0.
- Synchroniser: s = serial_in delayed SYNC_STAGES edges. The FSM acts only on s.
- FSM states: IDLE, DATA, PARITY, STOP, BREAK.
  - IDLE: s=0 -> DATA, counter=0. s=1 -> stay.
  - DATA: shift s into shift register at bit[counter] (LSB first); update running XOR; counter++. When counter reaches DATA_W-1, go to PARITY if PARITY_EN, else STOP.
  - PARITY: compare s against the running XOR (even parity: XOR of data bits equals parity bit) -> STOP.
  - STOP, s=1 (good stop):
    - Deliver the word and -> IDLE.
    - Delivery when rx_valid=0, or rx_valid&rx_ready on this edge: rx_data<=shift, parity_err<=mismatch, rx_valid<=1.
    - Otherwise: keep old word; overrun=1 for one cycle.
  - STOP, s=0: frame_err=1 for one cycle, word discarded, -> BREAK.
  - BREAK: wait for s=1, then -> IDLE. This prevents a held-low line from being taken as a new start bit.
- Latency: if the stop bit is captured by synchroniser stage 1 at edge E, rx_valid is 1 after edge E+SYNC_STAGES.
- Handshake:
  - rx_valid clears on the edge where rx_valid&rx_ready; rx_data/parity_err are stable while rx_valid=1.
  - Simultaneous accept and new-word delivery: new word loads, rx_valid stays 1, no overrun.
- Back-to-back: a start bit is accepted in the cycle immediately after STOP, so there is zero idle gap between frames.
- Reset mid-frame: everything returns to IDLE at once; the partial frame is lost and no pulses are emitted.
- Minimum frame length: 1 + DATA_W + PARITY_EN + 1 bits.

Decomposition:
- Shared package serial_link_pkg:
  - state enum typedef (IDLE, DATA, PARITY, STOP, BREAK).
  - constants LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1.
  - parity-mode constant (even).
  - The matching transmitter imports the same package.
- One sub-module, sync_chain:
  - parameter SYNC_STAGES.
  - async active-low reset, reset value 1.
  - instantiated once for serial_in.

Test Plan:
- Reset then idle line (serial_in=1 for 50 cycles) -> rx_valid, frame_err and overrun stay 0; rx_data=0x00.
- Frame 0xA5:
  - stimulus: rx_ready=1; bits 0,1,0,1,0,0,1,0,1,0(parity),1(stop).
  - response: rx_data=0xA5, parity_err=0, rx_valid high for exactly 1 cycle, at stop-capture edge +2.
- Frame 0x3C with parity bit 1 -> rx_data=0x3C, parity_err=1 with rx_valid.
- Bad stop:
  - stimulus: frame 0x81, stop=0, then line held 0 for 5 cycles, then 1.
  - response: frame_err pulse 1 cycle; no rx_valid; no false start. Next frame 0x7E is received correctly.
- Overrun, rx_ready=0, back-to-back frames 0x11 then 0x22:
  - rx_data holds 0x11, overrun pulses once.
  - Raising rx_ready afterwards -> rx_valid drops; 0x22 is never presented.
- Mid-frame reset (reset=0 after 4 data bits of 0xFF) -> all outputs 0 immediately; a following clean frame 0x5A is received correctly.
